instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer for the 16-bit RISC core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the 4-bit opcode into the combinational control unit and gates that unit's decoded strobes into single-cycle enables for the IR, PC, register file and data memory. It sits between the instruction/data memory handshakes and the datapath, and owns halt, run/stop and memory-timeout handling.

## Interface
- TIMEOUT, default 16: maximum cycles to wait for any memory ack before entering ERROR; legal range 1..255.
- HALT_OPCODE, default 4'hF: opcode that stops the core.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  start from IDLE; sampled at every retire, 0 means return to IDLE
- imem_req  out  1  instruction fetch request, held until ack
- imem_ack  in  1  instruction valid this cycle
- instr  in  16  instruction word; opcode = instr[15:12]
- opcode  out  4  registered IR opcode to control unit
- reg_wr, mem_rd, mem_wr, jump, cmp  in  1 each  decoded strobes from control unit
- ir_en  out  1  latch instr into IR
- pc_en  out  1  advance PC
- pc_sel  out  1  1 = branch/jump target, 0 = PC+1
- dmem_req  out  1  data memory request, held until ack
- dmem_we  out  1  write qualifier for dmem_req
- dmem_ack  in  1  data access complete
- rf_we  out  1  register file write enable
- halted  out  1  in HALTED
- err  out  1  sticky timeout flag
- state  out  3  current state encoding, for debug
- retired  out  16  retired instruction count

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, ERROR=7.
- IDLE: all strobes are 0. run=1 moves to FETCH.
- FETCH: imem_req=1. On imem_ack: ir_en=1 that cycle, then go to DECODE.
- DECODE: one cycle while the control unit settles on opcode. opcode==HALT_OPCODE goes to HALTED; anything else goes to EXEC.
- EXEC: one cycle.
  - mem_rd or mem_wr goes to MEM.
  - Otherwise reg_wr goes to WB.
  - Otherwise retire.
- MEM: dmem_req=1 and dmem_we=mem_wr. On dmem_ack: go to WB if mem_rd and reg_wr, otherwise retire.
- WB: rf_we=1 for one cycle, then retire.
- Retire happens on the cycle that leaves EXEC, MEM or WB:
  - pc_en=1 for exactly one cycle.
  - pc_sel = jump OR (cmp AND jump).
  - retired increments and wraps from 16'hFFFF to 0.
  - Next state is FETCH if run=1, otherwise IDLE.
- HALTED and ERROR are left only by reset. Neither retires, and pc_en stays 0.
- Timeout: the wait counter clears on entry to FETCH or MEM and increments on each cycle without ack. The first cycle that would reach TIMEOUT with no ack goes to ERROR and sets err. If ack arrives in the same cycle the counter expires, ack wins.
- mem_rd and mem_wr both 1 is treated as a write: dmem_we=1, no WB.

## Timing
- Reset (asynchronous) takes effect immediately, including mid-transaction:
  - state=IDLE.
  - opcode=0, retired=0.
  - All strobes, halted and err are 0.
  - Outstanding requests are dropped and no ack is remembered.
- All outputs are registered or decoded from state only, with no combinational input-to-output path. The one exception is ir_en: it is FETCH AND imem_ack.
- Minimum latency with ack in the first request cycle:
  - ALU with writeback: 4 cycles (F, D, E, WB).
  - No writeback: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
- Each wait cycle adds one cycle.
- opcode updates on the clock edge after ir_en and is stable from DECODE through retire.
- A request stays asserted, and the controller ignores the other memory's ack, until its own ack or timeout.

## Structure
- cpu_pkg holds the state encodings, HALT_OPCODE default, opcode width (4) and instruction width (16), shared with the control unit and datapath.
- One sub-module, wait_timer: a clearable up-counter with an expire output, sized to $clog2(TIMEOUT+1).
- The FSM, retire logic and retired counter live in instr_sequencer.

## Test plan
- ALU instruction, reg_wr=1, acks immediate: states 1,2,3,5,1; rf_we high 1 cycle; pc_en 1 cycle with pc_sel=0; retired 0→1.
- Load with dmem_ack delayed 3 cycles: dmem_req high 4 cycles with dmem_we=0; then WB; total 8 cycles; retired +1.
- Jump (jump=1, reg_wr=0): retires from EXEC with pc_sel=1; store path gives dmem_we=1 and no rf_we.
- instr[15:12]=4'hF: HALTED after DECODE, halted=1, no pc_en; run toggling has no effect; rst_n low returns IDLE.
- TIMEOUT=4, imem_ack never: err=1 and state=7 after 4 FETCH cycles. Ack on the 4th cycle instead gives no error.
- rst_n low mid-MEM clears all outputs immediately. Separately: run=0 at retire goes to IDLE; preload retired=16'hFFFF and retire once, giving 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC core: widths, halt opcode and the
// sequencer state encoding seen by the control unit and datapath.
package cpu_pkg;

   localparam int OPCODE_W = 4;
   localparam int INSTR_W  = 16;

   localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALTED = 3'd6,
      ST_ERROR  = 3'd7
   } seq_state_e;

   // States that wait on a memory ack and therefore run the timeout counter.
   function automatic logic is_wait_state(input seq_state_e s);
      return (s == ST_FETCH) || (s == ST_MEM);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Clearable up-counter that flags the cycle on which a memory wait would
// reach TIMEOUT cycles without an ack.
module wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !expire) begin
         count <= count + 1'b1;
      end
   end

   // Count holds the number of ack-less cycles already spent, so the current
   // cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
   assign expire = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 16-bit
// RISC core, with halt, run/stop and memory-timeout handling.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int                   TIMEOUT     = 16,
   parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   output logic                imem_req,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  instr,
   output logic [OPCODE_W-1:0] opcode,
   input  logic                reg_wr,
   input  logic                mem_rd,
   input  logic                mem_wr,
   input  logic                jump,
   input  logic                cmp,
   output logic                ir_en,
   output logic                pc_en,
   output logic                pc_sel,
   output logic                dmem_req,
   output logic                dmem_we,
   input  logic                dmem_ack,
   output logic                rf_we,
   output logic                halted,
   output logic                err,
   output logic [2:0]          state,
   output logic [15:0]         retired
);

   seq_state_e          state_q;
   seq_state_e          state_d;
   logic                retire;
   logic                timer_clr;
   logic                timer_inc;
   logic                expire;
   logic                dmem_we_q;
   logic                pc_en_q;
   logic                pc_sel_q;
   logic [OPCODE_W-1:0] opcode_q;
   logic [15:0]         retired_q;
   logic                unused_instr;

   assign unused_instr = ^instr[INSTR_W-OPCODE_W-1:0];

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (timer_clr),
      .inc    (timer_inc),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      retire    = 1'b0;
      ir_en     = 1'b0;
      timer_inc = 1'b0;
      timer_clr = !is_wait_state(state_q);
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               ir_en   = 1'b1;
               state_d = ST_DECODE;
            end else if (expire) begin
               state_d = ST_ERROR;
            end else begin
               timer_inc = 1'b1;
            end
         end
         ST_DECODE: begin
            state_d = (opcode_q == HALT_OPCODE) ? ST_HALTED : ST_EXEC;
         end
         ST_EXEC: begin
            if (mem_rd || mem_wr)  state_d = ST_MEM;
            else if (reg_wr)       state_d = ST_WB;
            else                   retire  = 1'b1;
         end
         ST_MEM: begin
            // A simultaneous read+write strobe is a store, so it never writes back.
            if (dmem_ack) begin
               if (mem_rd && reg_wr && !mem_wr) state_d = ST_WB;
               else                             retire  = 1'b1;
            end else if (expire) begin
               state_d = ST_ERROR;
            end else begin
               timer_inc = 1'b1;
            end
         end
         ST_WB: begin
            retire = 1'b1;
         end
         default: begin
            state_d = state_q;
         end
      endcase
      if (retire) state_d = run ? ST_FETCH : ST_IDLE;
   end

   // Retire bookkeeping is registered, so pc_en/pc_sel and the new count
   // appear together in the cycle after the retiring state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_q  <= '0;
         retired_q <= '0;
         pc_en_q   <= 1'b0;
         pc_sel_q  <= 1'b0;
         dmem_we_q <= 1'b0;
      end else begin
         if (ir_en) opcode_q <= instr[INSTR_W-1 -: OPCODE_W];
         if (retire) retired_q <= retired_q + 16'd1;
         pc_en_q  <= retire;
         pc_sel_q <= retire && (jump || (cmp && jump));
         if (state_d != ST_MEM)       dmem_we_q <= 1'b0;
         else if (state_q != ST_MEM)  dmem_we_q <= mem_wr;
      end
   end

   assign imem_req = (state_q == ST_FETCH);
   assign dmem_req = (state_q == ST_MEM);
   assign dmem_we  = dmem_we_q;
   assign rf_we    = (state_q == ST_WB);
   assign halted   = (state_q == ST_HALTED);
   assign err      = (state_q == ST_ERROR);
   assign state    = state_q;
   assign opcode   = opcode_q;
   assign retired  = retired_q;
   assign pc_en    = pc_en_q;
   assign pc_sel   = pc_sel_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: ALU, load, jump, store, halt, timeout,
// reset and retire-counter wrap scenarios.
module tb_instr_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        imem_req;
   logic        imem_ack;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic        reg_wr, mem_rd, mem_wr, jump, cmp;
   logic        ir_en, pc_en, pc_sel;
   logic        dmem_req, dmem_we, dmem_ack;
   logic        rf_we, halted, err;
   logic [2:0]  state;
   logic [15:0] retired;

   int total = 0;
   int bad   = 0;

   instr_sequencer #(
      .TIMEOUT     (4),
      .HALT_OPCODE (4'hF)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .imem_req (imem_req),
      .imem_ack (imem_ack),
      .instr    (instr),
      .opcode   (opcode),
      .reg_wr   (reg_wr),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .jump     (jump),
      .cmp      (cmp),
      .ir_en    (ir_en),
      .pc_en    (pc_en),
      .pc_sel   (pc_sel),
      .dmem_req (dmem_req),
      .dmem_we  (dmem_we),
      .dmem_ack (dmem_ack),
      .rf_we    (rf_we),
      .halted   (halted),
      .err      (err),
      .state    (state),
      .retired  (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=still_running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; instr = 16'h0000;
      reg_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; jump = 1'b0; cmp = 1'b0;
      dmem_ack = 1'b0;
      tick(); tick();
      chk("rst_state",   16'(state), 16'd0);
      chk("rst_opcode",  16'(opcode), 16'd0);
      chk("rst_retired", retired, 16'd0);
      chk("rst_strobes", 16'({imem_req, ir_en, pc_en, pc_sel, dmem_req, dmem_we, rf_we, halted, err}), 16'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_hold", 16'(state), 16'd0);

      // ALU with writeback, immediate acks
      run = 1'b1; imem_ack = 1'b1; instr = 16'h1234; reg_wr = 1'b1;
      tick();
      chk("alu_f_state", 16'(state), 16'd1);
      chk("alu_f_req",   16'(imem_req), 16'd1);
      chk("alu_f_ir_en", 16'(ir_en), 16'd1);
      tick();
      chk("alu_d_state", 16'(state), 16'd2);
      chk("alu_d_opcode", 16'(opcode), 16'd1);
      chk("alu_d_req",   16'(imem_req), 16'd0);
      tick();
      chk("alu_e_state", 16'(state), 16'd3);
      chk("alu_e_rf_we", 16'(rf_we), 16'd0);
      tick();
      chk("alu_wb_state", 16'(state), 16'd5);
      chk("alu_wb_rf_we", 16'(rf_we), 16'd1);
      chk("alu_wb_pc_en", 16'(pc_en), 16'd0);
      tick();
      chk("alu_ret_state",  16'(state), 16'd1);
      chk("alu_ret_rf_we",  16'(rf_we), 16'd0);
      chk("alu_ret_pc_en",  16'(pc_en), 16'd1);
      chk("alu_ret_pc_sel", 16'(pc_sel), 16'd0);
      chk("alu_ret_count",  retired, 16'd1);

      // Load, dmem_ack on the 4th MEM cycle (counter at its limit, ack wins)
      instr = 16'h2000; reg_wr = 1'b1; mem_rd = 1'b1; dmem_ack = 1'b0;
      tick();
      chk("ld_d_state",  16'(state), 16'd2);
      chk("ld_d_pc_en",  16'(pc_en), 16'd0);
      chk("ld_d_opcode", 16'(opcode), 16'd2);
      tick();
      chk("ld_e_state", 16'(state), 16'd3);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ld_mem_state", 16'(state), 16'd4);
         chk("ld_mem_req",   16'(dmem_req), 16'd1);
         chk("ld_mem_we",    16'(dmem_we), 16'd0);
         if (i == 3) dmem_ack = 1'b1;
      end
      tick();
      chk("ld_wb_state", 16'(state), 16'd5);
      chk("ld_wb_rf_we", 16'(rf_we), 16'd1);
      chk("ld_wb_req",   16'(dmem_req), 16'd0);
      chk("ld_wb_err",   16'(err), 16'd0);
      dmem_ack = 1'b0;
      tick();
      chk("ld_ret_state", 16'(state), 16'd1);
      chk("ld_ret_pc_en", 16'(pc_en), 16'd1);
      chk("ld_ret_count", retired, 16'd2);

      // Jump retires straight from EXEC
      instr = 16'h3000; reg_wr = 1'b0; mem_rd = 1'b0; jump = 1'b1;
      tick(); tick();
      chk("jmp_e_state", 16'(state), 16'd3);
      tick();
      chk("jmp_ret_state",  16'(state), 16'd1);
      chk("jmp_ret_pc_en",  16'(pc_en), 16'd1);
      chk("jmp_ret_pc_sel", 16'(pc_sel), 16'd1);
      chk("jmp_ret_rf_we",  16'(rf_we), 16'd0);
      chk("jmp_ret_count",  retired, 16'd3);

      // Store, immediate dmem_ack
      instr = 16'h4000; jump = 1'b0; mem_wr = 1'b1; dmem_ack = 1'b1;
      tick(); tick(); tick();
      chk("st_mem_state", 16'(state), 16'd4);
      chk("st_mem_req",   16'(dmem_req), 16'd1);
      chk("st_mem_we",    16'(dmem_we), 16'd1);
      chk("st_mem_rf_we", 16'(rf_we), 16'd0);
      tick();
      chk("st_ret_state",  16'(state), 16'd1);
      chk("st_ret_pc_en",  16'(pc_en), 16'd1);
      chk("st_ret_pc_sel", 16'(pc_sel), 16'd0);
      chk("st_ret_we",     16'(dmem_we), 16'd0);
      chk("st_ret_count",  retired, 16'd4);

      // mem_rd and mem_wr together behave as a store even with reg_wr
      instr = 16'h5000; mem_rd = 1'b1; mem_wr = 1'b1; reg_wr = 1'b1;
      tick(); tick(); tick();
      chk("rw_mem_we", 16'(dmem_we), 16'd1);
      tick();
      chk("rw_ret_state", 16'(state), 16'd1);
      chk("rw_ret_rf_we", 16'(rf_we), 16'd0);
      chk("rw_ret_count", retired, 16'd5);

      // Asynchronous reset in the middle of a MEM wait
      instr = 16'h9000; mem_wr = 1'b0; mem_rd = 1'b1; reg_wr = 1'b1; dmem_ack = 1'b0;
      tick(); tick(); tick();
      chk("mr_mem_req", 16'(dmem_req), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_state",    16'(state), 16'd0);
      chk("mr_dmem_req", 16'(dmem_req), 16'd0);
      chk("mr_imem_req", 16'(imem_req), 16'd0);
      chk("mr_opcode",   16'(opcode), 16'd0);
      chk("mr_retired",  retired, 16'd0);
      run = 1'b0;
      tick();
      rst_n = 1'b1; mem_rd = 1'b0; reg_wr = 1'b0;
      tick();
      chk("mr_idle", 16'(state), 16'd0);

      // run=0 sampled at retire returns to IDLE
      run = 1'b1; instr = 16'h6000;
      tick();
      chk("stop_f_state", 16'(state), 16'd1);
      tick();
      run = 1'b0;
      tick();
      chk("stop_e_state", 16'(state), 16'd3);
      tick();
      chk("stop_ret_state", 16'(state), 16'd0);
      chk("stop_ret_pc_en", 16'(pc_en), 16'd1);
      chk("stop_ret_count", retired, 16'd1);
      tick();
      chk("stop_idle_state", 16'(state), 16'd0);
      chk("stop_idle_pc_en", 16'(pc_en), 16'd0);

      // Retired counter wraps from FFFF to 0
      force dut.retired_q = 16'hFFFF;
      #1 release dut.retired_q;
      #1;
      chk("wrap_preload", retired, 16'hFFFF);
      run = 1'b1; instr = 16'h7000;
      tick(); tick(); tick(); tick();
      chk("wrap_state", 16'(state), 16'd1);
      chk("wrap_count", retired, 16'h0000);

      // Halt opcode
      instr = 16'hF000;
      tick();
      chk("halt_d_opcode", 16'(opcode), 16'hF);
      tick();
      chk("halt_state",  16'(state), 16'd6);
      chk("halt_flag",   16'(halted), 16'd1);
      chk("halt_pc_en",  16'(pc_en), 16'd0);
      run = 1'b0;
      tick();
      chk("halt_run0", 16'(state), 16'd6);
      run = 1'b1;
      tick();
      chk("halt_run1",    16'(state), 16'd6);
      chk("halt_pc_en2",  16'(pc_en), 16'd0);
      chk("halt_retired", retired, 16'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("halt_rst_state",  16'(state), 16'd0);
      chk("halt_rst_halted", 16'(halted), 16'd0);
      chk("halt_rst_opcode", 16'(opcode), 16'd0);

      // Fetch timeout with TIMEOUT=4
      run = 1'b0;
      tick();
      rst_n = 1'b1; imem_ack = 1'b0; run = 1'b1; instr = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("to_fetch_state", 16'(state), 16'd1);
         chk("to_fetch_req",   16'(imem_req), 16'd1);
         chk("to_fetch_err",   16'(err), 16'd0);
      end
      tick();
      chk("to_state", 16'(state), 16'd7);
      chk("to_err",   16'(err), 16'd1);
      chk("to_req",   16'(imem_req), 16'd0);
      imem_ack = 1'b1; run = 1'b0;
      tick();
      chk("to_sticky_state", 16'(state), 16'd7);
      chk("to_sticky_err",   16'(err), 16'd1);
      chk("to_sticky_pc_en", 16'(pc_en), 16'd0);

      // Ack on the 4th fetch cycle beats the timeout
      #2 rst_n = 1'b0;
      #1;
      chk("ta_rst_err",   16'(err), 16'd0);
      chk("ta_rst_state", 16'(state), 16'd0);
      tick();
      rst_n = 1'b1; imem_ack = 1'b0; run = 1'b1; instr = 16'h8000;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ta_fetch_state", 16'(state), 16'd1);
         if (i == 3) imem_ack = 1'b1;
      end
      #1;
      chk("ta_ir_en", 16'(ir_en), 16'd1);
      tick();
      chk("ta_d_state",  16'(state), 16'd2);
      chk("ta_d_err",    16'(err), 16'd0);
      chk("ta_d_opcode", 16'(opcode), 16'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
